mux16_arbiter: RTL
==================

MUX16_ARBITER -- requirements
Module: mux16_arbiter

Interface
REQ-001 Parameter WIDTH, default 3: bit width of each requester data word and of output y.
REQ-002 Parameter BURST, default 1, legal range 1..15: maximum transfers per grant.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req  input  16  per-requester request; bit i high means requester i has data on d[i].
REQ-006 d  input  16*WIDTH  packed requester data; d[i*WIDTH +: WIDTH] belongs to requester i.
REQ-007 y_ready  input  1  consumer accepts y in the current cycle.
REQ-008 sel  output  4  registered mux select; index of the currently granted requester.
REQ-009 gnt  output  16  registered one-hot grant; all zeros when no grant is active.
REQ-010 y  output  WIDTH  mux output d[sel]; forced to zero when y_valid is low.
REQ-011 y_valid  output  1  high while in GRANT.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-013 The block SHALL hold an internal 4-bit round-robin pointer ptr and a 4-bit beat counter cnt.
REQ-014 Arbitration SHALL pick the first set req bit searching ptr, ptr+1, ... 15, 0, ... ptr-1 (mod 16).
REQ-015 IDLE, req != 0 at the clock edge: next state GRANT; sel = winner; gnt = one-hot(winner); cnt = 0.
REQ-016 IDLE, req == 0: remain IDLE; gnt = 0; sel holds its last value.
REQ-017 Latency SHALL be one cycle from the req sample in IDLE to y_valid high.
REQ-018 GRANT: y SHALL equal d[sel] combinationally, so changes on d[sel] appear on y in the same cycle.
REQ-019 A transfer SHALL occur on every edge where y_valid && y_ready && req[sel].
REQ-020 Transfer with cnt < BURST-1: stay in GRANT; cnt increments; sel and gnt hold.
REQ-021 Transfer with cnt == BURST-1 (release):
  - ptr = sel+1, wrapping 15 -> 0.
  - The block SHALL re-arbitrate in the same cycle using the current req with the updated ptr.
  - Winner found: stay in GRANT with the new sel/gnt and cnt = 0 (back-to-back, no idle bubble).
  - No winner: go to IDLE with gnt = 0.
REQ-022 req[sel] low in GRANT (abort): no transfer; ptr = sel+1; re-arbitrate exactly as in REQ-021.
REQ-023 y_ready low with req[sel] high in GRANT: sel, gnt, cnt, y_valid and y SHALL hold (stall).
REQ-024 A single continuous requester SHALL be re-granted on every release: same sel, cnt restarts at 0.
REQ-025 Changes on req bits other than req[sel] SHALL not affect GRANT until the next release or abort.
REQ-026 gnt SHALL always be zero or one-hot, and when nonzero SHALL equal one-hot(sel).

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, ptr=0, cnt=0, sel=0, gnt=0, y_valid=0, y=0.
REQ-028 Reset asserted mid-GRANT SHALL discard the grant; no transfer is counted in that cycle.
REQ-029 Arbitration SHALL resume on the first rising edge after rst_n deasserts.

Verification
REQ-030 Single requester: after reset, req=0x0001, d0=3'b111, y_ready=1.
  - Next cycle: gnt=0x0001, sel=0, y=3'b111, y_valid=1.
  - Every following cycle: the same grant is repeated.
REQ-031 Full rotation: req=0xFFFF, y_ready=1, BURST=1 -> sel steps 0,1,...,15,0 one per cycle with no idle cycle.
REQ-032 Sparse requesters and fairness: req bits 3 and 9 set, ptr=0 -> sel sequence 3,9,3,9; y tracks d3 then d9.
REQ-033 Stall then burst:
  - Stall: y_ready=0 for 5 cycles in GRANT -> sel, gnt, y and y_valid stay constant.
  - Burst: BURST=4, req=0x0041 -> requester 0 gets 4 transfers, then requester 6 gets 4 transfers.
REQ-034 Abort: requester 5 granted, req[5] drops before y_ready.
  - req=0 otherwise: next cycle y_valid=0, gnt=0.
  - A later req=0x0020|0x0001 grants requester 0 next, because ptr=6 and the search wraps past 15.
REQ-035 Reset mid-operation: rst_n pulsed low during GRANT.
  - Outputs zero immediately, without waiting for a clock edge.
  - After release with req=0xFFFF, the first grant is sel=0.

Source files
------------

// File: rtl/mux16_arbiter_if.sv
// Bus between sixteen requesters, the round-robin arbiter and one consumer.
// Master drives requests, data and ready; slave (the arbiter) drives the grant side.
interface mux16_arbiter_if #(
  parameter int WIDTH = 3
);
  logic [15:0]          req;
  logic [16*WIDTH-1:0]  d;
  logic                 y_ready;
  logic [3:0]           sel;
  logic [15:0]          gnt;
  logic [WIDTH-1:0]     y;
  logic                 y_valid;

  modport master (output req, d, y_ready, input sel, gnt, y, y_valid);
  modport slave  (input req, d, y_ready, output sel, gnt, y, y_valid);
endinterface

// File: rtl/mux16_arbiter.sv
// Sixteen-way round-robin arbiter with a registered select driving a data mux.
// A grant lasts up to BURST transfers; release and abort re-arbitrate in the same cycle.
module mux16_arbiter #(
  parameter int WIDTH = 3,
  parameter int BURST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mux16_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] gnt_q, gnt_d;

  logic [3:0]  rel_ptr;
  logic [4:0]  idle_win;
  logic [4:0]  rel_win;
  logic        rel_go;

  // Returns {found, index} of the first set request at or after start, wrapping mod 16.
  function automatic logic [4:0] pick(input logic [15:0] r, input logic [3:0] start);
    logic [4:0] res;
    logic [3:0] idx;
    res = '0;
    for (int k = 15; k >= 0; k--) begin
      idx = start + 4'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  // Both candidate winners are computed every cycle: one for leaving IDLE, one for a release.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    rel_go   = 1'b0;
    rel_ptr  = sel_q + 4'd1;
    idle_win = pick(bus.req, ptr_q);
    rel_win  = pick(bus.req, rel_ptr);

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (idle_win[4]) begin
          state_d = GRANT;
          sel_d   = idle_win[3:0];
          gnt_d   = 16'b1 << idle_win[3:0];
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // A dropped request aborts the grant; the last beat of a burst releases it.
        rel_go = !bus.req[sel_q] || (bus.y_ready && (cnt_q == LAST_BEAT));
        if (rel_go) begin
          ptr_d = rel_ptr;
          cnt_d = '0;
          if (rel_win[4]) begin
            sel_d = rel_win[3:0];
            gnt_d = 16'b1 << rel_win[3:0];
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (bus.y_ready) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign bus.sel     = sel_q;
  assign bus.gnt     = gnt_q;
  assign bus.y_valid = (state_q == GRANT);
  assign bus.y       = bus.y_valid ? bus.d[int'(sel_q)*WIDTH +: WIDTH] : '0;

endmodule
